// File: rtl/redmule_x_feeder.sv
// X operand feeder: accepts streamer rows, zero-masks elements beyond the row length and
// writes them into the X buffer pad one tile at a time, pacing tiles with full / pad-free handshakes.
module redmule_x_feeder #(
    parameter int unsigned DW    = 288,
    parameter int unsigned BITW  = 16,
    parameter int unsigned W     = 12,
    localparam int unsigned ELEMS = DW / BITW,
    localparam int unsigned RW    = $clog2(W + 1),
    localparam int unsigned EW    = $clog2(ELEMS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [RW-1:0] cfg_rows_i,
    input  logic [15:0]   cfg_tiles_i,
    input  logic [EW-1:0] cfg_elems_i,
    input  logic          stream_valid_i,
    output logic          stream_ready_o,
    input  logic [DW-1:0] stream_data_i,
    output logic          load_o,
    output logic [DW-1:0] wdata_o,
    input  logic          tile_full_i,
    output logic          rst_w_index_o,
    input  logic          pad_free_i,
    output logic          busy_o,
    output logic          done_o
);

    // Streamer handshake: a beat transfers on a cycle where stream_valid_i and
    // stream_ready_o are both high; ready depends on state only, never on valid.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_FULL = 3'd2,
        WAIT_FREE = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rows_q;
    logic [15:0]   tiles_q;
    logic [EW-1:0] elems_q;
    logic [RW-1:0] row_cnt_q;
    logic [15:0]   tile_cnt_q;
    logic          free_q;
    logic          load_q;
    logic [DW-1:0] wdata_q;
    logic          busy_q;
    logic          done_q;

    logic          accept;
    logic          last_row;
    logic          last_tile;
    logic          free_avail;
    logic [DW-1:0] masked;

    assign stream_ready_o = (state_q == LOAD);
    assign accept         = stream_valid_i & stream_ready_o;
    assign last_row       = (row_cnt_q == RW'(rows_q - 1'b1));
    assign last_tile      = (tile_cnt_q == (tiles_q - 16'd1));
    assign free_avail     = free_q | pad_free_i;

    // The ack is combinational so the buffer sees it in the very cycle it raised full.
    assign rst_w_index_o  = (state_q == WAIT_FULL) & tile_full_i;

    assign load_o  = load_q;
    assign wdata_o = wdata_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

    always_comb begin
        masked = '0;
        for (int e = 0; e < int'(ELEMS); e++) begin
            if (e < int'(elems_q)) begin
                masked[e*BITW +: BITW] = stream_data_i[e*BITW +: BITW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (cfg_tiles_i == 16'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept && last_row) begin
                    state_d = WAIT_FULL;
                end
            end
            WAIT_FULL: begin
                if (tile_full_i) begin
                    state_d = last_tile ? DONE : WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (free_avail) begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            tiles_q    <= '0;
            elems_q    <= '0;
            row_cnt_q  <= '0;
            tile_cnt_q <= '0;
            free_q     <= 1'b0;
            load_q     <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            tiles_q    <= '0;
            elems_q    <= '0;
            row_cnt_q  <= '0;
            tile_cnt_q <= '0;
            free_q     <= 1'b0;
            load_q     <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == DONE);
            load_q  <= accept;
            if (accept) begin
                wdata_q <= masked;
            end

            if (state_q == IDLE && start_i) begin
                rows_q     <= cfg_rows_i;
                tiles_q    <= cfg_tiles_i;
                elems_q    <= cfg_elems_i;
                row_cnt_q  <= '0;
                tile_cnt_q <= '0;
            end else if (accept) begin
                row_cnt_q <= last_row ? '0 : row_cnt_q + 1'b1;
            end

            if (state_q == WAIT_FULL && tile_full_i) begin
                tile_cnt_q <= tile_cnt_q + 16'd1;
            end

            // Pad-free credit: consuming it on the way back to LOAD beats a same-cycle pulse.
            if (state_q == IDLE) begin
                free_q <= 1'b0;
            end else if (state_q == WAIT_FREE && free_avail) begin
                free_q <= 1'b0;
            end else if (pad_free_i &&
                         (state_q == LOAD || state_q == WAIT_FULL || state_q == WAIT_FREE)) begin
                free_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_redmule_x_feeder.sv
// Directed bench for redmule_x_feeder: drivers push expected rows into a queue,
// a negedge monitor pops and compares every load_o write.
module tb_redmule_x_feeder;

    localparam int DW    = 288;
    localparam int BITW  = 16;
    localparam int W     = 12;
    localparam int ELEMS = DW / BITW;
    localparam int RW    = $clog2(W + 1);
    localparam int EW    = $clog2(ELEMS + 1);

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          start;
    logic [RW-1:0] cfg_rows;
    logic [15:0]   cfg_tiles;
    logic [EW-1:0] cfg_elems;
    logic          stream_valid;
    logic          stream_ready;
    logic [DW-1:0] stream_data;
    logic          load;
    logic [DW-1:0] wdata;
    logic          tile_full;
    logic          rst_w_index;
    logic          pad_free;
    logic          busy;
    logic          done;

    logic [DW-1:0] exp_q[$];
    int            checks;
    int            errors;
    int            load_cnt;

    redmule_x_feeder #(.DW(DW), .BITW(BITW), .W(W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .start_i        (start),
        .cfg_rows_i     (cfg_rows),
        .cfg_tiles_i    (cfg_tiles),
        .cfg_elems_i    (cfg_elems),
        .stream_valid_i (stream_valid),
        .stream_ready_o (stream_ready),
        .stream_data_i  (stream_data),
        .load_o         (load),
        .wdata_o        (wdata),
        .tile_full_i    (tile_full),
        .rst_w_index_o  (rst_w_index),
        .pad_free_i     (pad_free),
        .busy_o         (busy),
        .done_o         (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && load === 1'b1) begin
            load_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load got %h expected none", wdata);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (wdata !== e) begin
                    errors++;
                    $display("FAIL wdata got %h expected %h", wdata, e);
                end
            end
        end
    end

    // driver tasks
    task automatic start_job(input int rows, input int tiles, input int elems);
        cfg_rows  = RW'(rows);
        cfg_tiles = 16'(tiles);
        cfg_elems = EW'(elems);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DW-1:0] e);
        int budget;
        budget       = 0;
        stream_valid = 1'b1;
        stream_data  = d;
        while (!stream_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!stream_ready) begin
            chk("beat_ready_timeout", 32'(stream_ready), 32'd1);
        end else begin
            exp_q.push_back(e);
            tick();
        end
        stream_valid = 1'b0;
    endtask

    // Called right after the tile's last beat was accepted (first WAIT_FULL cycle).
    task automatic ack_tile();
        chk("ready_in_wait_full", 32'(stream_ready), 32'd0);
        tick();
        chk("no_ack_before_full", 32'(rst_w_index), 32'd0);
        tile_full = 1'b1;
        #1;
        chk("rst_w_index_pulse", 32'(rst_w_index), 32'd1);
        tick();
        tile_full = 1'b0;
        #1;
        chk("rst_w_index_low", 32'(rst_w_index), 32'd0);
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (done !== 1'b1 && budget < 10) begin
            tick();
            budget++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] da, db, dc, ones, mask5, d;
        int            loads_before;

        checks       = 0;
        errors       = 0;
        load_cnt     = 0;
        rst_n        = 1'b0;
        clear        = 1'b0;
        start        = 1'b0;
        cfg_rows     = '0;
        cfg_tiles    = '0;
        cfg_elems    = '0;
        stream_valid = 1'b0;
        stream_data  = '0;
        tile_full    = 1'b0;
        pad_free     = 1'b0;
        da    = {72{4'hA}};
        db    = {72{4'hB}};
        dc    = {72{4'hC}};
        ones  = {DW{1'b1}};
        mask5 = {{(DW-80){1'b0}}, {80{1'b1}}};

        repeat (3) tick();
        chk("rst_ready", 32'(stream_ready), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_wdata_zero", 32'(wdata == '0), 32'd1);
        chk("rst_ack", 32'(rst_w_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single tile, unmasked
        start_job(3, 1, 18);
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        chk("t1_ready_in_load", 32'(stream_ready), 32'd1);
        send_beat(da, da);
        chk("t1_load_latency", 32'(load), 32'd1);
        send_beat(db, db);
        send_beat(dc, dc);
        chk("t1_last_load_in_wait_full", 32'(load), 32'd1);
        ack_tile();
        chk("t1_done_not_yet", 32'(done), 32'd0);
        chk("t1_busy_in_done_state", 32'(busy), 32'd1);
        tick();
        chk("t1_done_two_after_ack", 32'(done), 32'd1);
        chk("t1_busy_low", 32'(busy), 32'd0);
        tick();
        chk("t1_done_cleared", 32'(done), 32'd0);

        // Masking: 5 valid elements
        start_job(1, 1, 5);
        send_beat(ones, mask5);
        ack_tile();
        wait_done();

        // Backpressure: credit withheld, then delivered
        start_job(2, 2, 18);
        send_beat(da, da);
        send_beat(db, db);
        ack_tile();
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold_ready", 32'(stream_ready), 32'd0);
            chk("bp_hold_busy", 32'(busy), 32'd1);
            tick();
        end
        pad_free = 1'b1;
        tick();
        pad_free = 1'b0;
        chk("bp_ready_after_free", 32'(stream_ready), 32'd1);
        send_beat(dc, dc);
        send_beat(da, da);
        ack_tile();
        wait_done();

        // Early credit during second tile's LOAD
        start_job(2, 3, 18);
        send_beat(da, da);
        send_beat(db, db);
        ack_tile();
        pad_free = 1'b1;
        tick();
        pad_free = 1'b0;
        chk("ec_ready_tile2", 32'(stream_ready), 32'd1);
        pad_free = 1'b1;
        send_beat(dc, dc);
        pad_free = 1'b0;
        send_beat(db, db);
        ack_tile();
        chk("ec_one_wait_free_cycle", 32'(stream_ready), 32'd0);
        tick();
        chk("ec_credit_used", 32'(stream_ready), 32'd1);
        send_beat(da, da);
        send_beat(dc, dc);
        ack_tile();
        wait_done();

        // Zero tiles
        start_job(1, 0, 18);
        chk("z_no_ready", 32'(stream_ready), 32'd0);
        chk("z_done_not_first", 32'(done), 32'd0);
        tick();
        chk("z_done_second", 32'(done), 32'd1);
        chk("z_no_ready_2", 32'(stream_ready), 32'd0);
        tick();

        // Mid-job clear on an accepting cycle
        start_job(3, 1, 18);
        send_beat(da, da);
        stream_valid = 1'b1;
        stream_data  = db;
        clear        = 1'b1;
        tick();
        clear        = 1'b0;
        stream_valid = 1'b0;
        chk("clr_no_load", 32'(load), 32'd0);
        chk("clr_wdata_zero", 32'(wdata == '0), 32'd1);
        chk("clr_ready", 32'(stream_ready), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_ack", 32'(rst_w_index), 32'd0);
        tick();

        // Stalled stream, rows=W, ignored mid-job starts
        loads_before = load_cnt;
        start_job(W, 1, ELEMS);
        for (int i = 0; i < W; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cfg_rows  = RW'(1);
                cfg_tiles = 16'd0;
                start     = (g == 0);
                tick();
                start     = 1'b0;
            end
            d = {9{32'hC0DE_0000 + 32'(i)}};
            if (i == W - 1) begin
                chk("st_ready_before_last", 32'(stream_ready), 32'd1);
            end
            send_beat(d, d);
        end
        start = 1'b1;
        ack_tile();
        start = 1'b0;
        wait_done();
        tick();
        chk("st_twelve_loads", 32'(load_cnt - loads_before), 32'(W));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("idle_at_end", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
